// File: rtl/pktgen_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_PORTS AXI-Stream sources onto one output.
// Grant is held from the first beat of a packet through its TLAST handshake.
module pktgen_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 512
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*DATA_W-1:0]     AXIS_IN_TDATA,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] AXIS_IN_TKEEP,
  input  logic [NUM_PORTS-1:0]            AXIS_IN_TLAST,
  input  logic [NUM_PORTS-1:0]            AXIS_IN_TVALID,
  output logic [NUM_PORTS-1:0]            AXIS_IN_TREADY,
  output logic [DATA_W-1:0]               AXIS_OUT_TDATA,
  output logic [DATA_W/8-1:0]             AXIS_OUT_TKEEP,
  output logic                            AXIS_OUT_TLAST,
  output logic                            AXIS_OUT_TVALID,
  input  logic                            AXIS_OUT_TREADY,
  input  logic [NUM_PORTS-1:0]            PORT_ENABLE,
  output logic                            GRANT_VALID,
  output logic [2:0]                      GRANT_IDX,
  output logic [31:0]                     PACKET_COUNT
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               gv_q, gv_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [NUM_PORTS-1:0] cand;
  logic [IDX_W-1:0]     pick;
  logic                 pick_ok;
  logic                 xfer_hs;

  assign cand = AXIS_IN_TVALID & PORT_ENABLE;

  // Round-robin search starting one past the previous winner
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= int'(NUM_PORTS); k++) begin
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
        if (!pick_ok && cand[j] && (j == ((int'(last_q) + k) % int'(NUM_PORTS)))) begin
          pick    = IDX_W'(j);
          pick_ok = 1'b1;
        end
      end
    end
  end

  // Output mux and ready steering; everything is quiet outside XFER
  always_comb begin
    AXIS_OUT_TDATA  = '0;
    AXIS_OUT_TKEEP  = '0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_IN_TREADY  = '0;
    if (state_q == S_XFER) begin
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
        if (grant_q == IDX_W'(j)) begin
          AXIS_OUT_TDATA    = AXIS_IN_TDATA[j*DATA_W +: DATA_W];
          AXIS_OUT_TKEEP    = AXIS_IN_TKEEP[j*KEEP_W +: KEEP_W];
          AXIS_OUT_TLAST    = AXIS_IN_TLAST[j];
          AXIS_OUT_TVALID   = AXIS_IN_TVALID[j];
          AXIS_IN_TREADY[j] = AXIS_OUT_TREADY;
        end
      end
    end
  end

  assign xfer_hs = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

  // Next-state: enable mask only matters while choosing a new owner
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    gv_d      = gv_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          last_d  = pick;
          gv_d    = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer_hs && AXIS_OUT_TLAST) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          gv_d      = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_PORTS - 1);
      gv_q      <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      gv_q      <= gv_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign GRANT_VALID  = gv_q;
  assign GRANT_IDX    = grant_q;
  assign PACKET_COUNT = pkt_cnt_q;

endmodule

// File: tb/tb_pktgen_arbiter.sv
// Bench for pktgen_arbiter: directed scenarios plus random traffic, checked
// every cycle against a packet-level reference model of the arbiter.
module tb_pktgen_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N*DW-1:0] in_tdata;
  logic [N*KW-1:0] in_tkeep;
  logic [N-1:0]    in_tlast, in_tvalid, in_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tlast, out_tvalid, out_tready;
  logic [N-1:0]    port_enable;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic [31:0]     packet_count;

  pktgen_arbiter #(.NUM_PORTS(N), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TLAST(in_tlast),
    .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(in_tready),
    .AXIS_OUT_TDATA(out_tdata), .AXIS_OUT_TKEEP(out_tkeep), .AXIS_OUT_TLAST(out_tlast),
    .AXIS_OUT_TVALID(out_tvalid), .AXIS_OUT_TREADY(out_tready),
    .PORT_ENABLE(port_enable), .GRANT_VALID(grant_valid), .GRANT_IDX(grant_idx),
    .PACKET_COUNT(packet_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Source model: per-port packet stream state
  int  pk_left[N];
  int  plen[N];
  int  pbeat[N];
  int  pseq[N];
  bit  vhold[N];
  int  len_min, len_max;
  int unsigned valid_pct, rdy_pct;
  bit  rdy_q[$];

  // Arbiter reference: who owns the output, who won last, packets delivered
  bit          m_busy;
  int          m_port;
  int          m_last;
  logic [31:0] m_count;

  // Observation log of beats accepted downstream
  logic [7:0] obs_data[$];
  int         obs_port[$];
  bit         obs_last[$];
  int         n_pkts, cyc, t_in, t_out, t_last;

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkword(int p, int s, int b);
    return {13'd0, 3'(p), 8'(s), 8'(b + 1)};
  endfunction

  task automatic drive();
    logic [31:0] w;
    for (int i = 0; i < N; i++) begin
      if (!vhold[i]) vhold[i] = (pk_left[i] != 0) && ($urandom_range(99) < valid_pct);
      w = mkword(i, pseq[i], pbeat[i]);
      in_tvalid[i]         = vhold[i];
      in_tlast[i]          = (pbeat[i] == plen[i] - 1);
      in_tdata[i*DW +: DW] = {16{w}};
      in_tkeep[i*KW +: KW] = {w, ~w};
    end
    if (rdy_q.size() > 0) out_tready = rdy_q.pop_front();
    else out_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic check_cycle();
    logic [N-1:0]  etr;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    logic          el, ev;
    logic [31:0]   w;
    etr = '0; ed = '0; ek = '0; el = 1'b0; ev = 1'b0;
    if (m_busy) begin
      w   = mkword(m_port, pseq[m_port], pbeat[m_port]);
      ed  = {16{w}};
      ek  = {w, ~w};
      el  = (pbeat[m_port] == plen[m_port] - 1);
      ev  = vhold[m_port];
      etr = N'(out_tready) << m_port;
    end
    chk32("grant_valid", 32'(grant_valid), 32'(m_busy));
    if (m_busy) chk32("grant_idx", 32'(grant_idx), 32'(m_port));
    chk32("out_tvalid", 32'(out_tvalid), 32'(ev));
    chk32("out_tlast", 32'(out_tlast), 32'(el));
    chkw("out_tdata", out_tdata, ed);
    chkw("out_tkeep", DW'(out_tkeep), DW'(ek));
    chk32("in_tready", 32'(in_tready), 32'(etr));
    chk32("packet_count", packet_count, m_count);
  endtask

  task automatic advance(int p);
    vhold[p] = 1'b0;
    if (pbeat[p] == plen[p] - 1) begin
      pbeat[p] = 0;
      pseq[p]++;
      if (pk_left[p] > 0) pk_left[p]--;
      plen[p] = int'($urandom_range(len_max, len_min));
    end else begin
      pbeat[p]++;
    end
  endtask

  task automatic step();
    bit hs, lst;
    int best, bd, d;
    drive();
    @(negedge clk);
    check_cycle();
    if (t_in < 0 && in_tvalid != '0) t_in = cyc;
    if (t_out < 0 && out_tvalid) t_out = cyc;
    if (out_tvalid && out_tready) begin
      obs_data.push_back(out_tdata[7:0]);
      obs_port.push_back(int'(grant_idx));
      obs_last.push_back(out_tlast);
      if (out_tlast) begin n_pkts++; t_last = cyc; end
    end
    hs = m_busy && vhold[m_port] && out_tready;
    @(posedge clk); #1;
    cyc++;
    if (m_busy) begin
      if (hs) begin
        lst = (pbeat[m_port] == plen[m_port] - 1);
        advance(m_port);
        if (lst) begin m_count++; m_busy = 1'b0; end
      end
    end else begin
      // Winner: the requesting enabled port at the smallest distance past m_last
      best = -1; bd = N;
      for (int i = 0; i < N; i++) begin
        if (in_tvalid[i] && port_enable[i]) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < bd) begin bd = d; best = i; end
        end
      end
      if (best >= 0) begin m_busy = 1'b1; m_port = best; m_last = best; end
    end
  endtask

  task automatic run_pkts(int target, int budget, string tag);
    int b = budget;
    while (n_pkts < target && b > 0) begin step(); b--; end
    chk32(tag, 32'(n_pkts >= target), 32'd1);
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_port.delete(); obs_last.delete();
    n_pkts = 0; t_in = -1; t_out = -1; t_last = -1;
  endtask

  task automatic reset_model();
    m_busy = 1'b0; m_port = 0; m_last = N - 1; m_count = '0;
    for (int i = 0; i < N; i++) begin pk_left[i] = 0; pbeat[i] = 0; vhold[i] = 1'b0; end
    rdy_q.delete();
    in_tvalid = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    reset_model();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic set_len(int l);
    len_min = l; len_max = l;
    for (int i = 0; i < N; i++) plen[i] = l;
  endtask

  initial begin
    int cnt[N];
    int pk;
    resetn = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
    out_tready = 1'b0; port_enable = '1; valid_pct = 100; rdy_pct = 100;
    for (int i = 0; i < N; i++) pseq[i] = 0;
    set_len(1);
    reset_model();
    cyc = 0;
    clear_obs();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk32("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk32("rst_packet_count", packet_count, 32'd0);
    chk32("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk32("rst_in_tready", 32'(in_tready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single 3-beat packet from port 0
    clear_obs(); set_len(3); pk_left[0] = 1;
    run_pkts(1, 30, "t1_timeout");
    step(); step();
    chk32("t1_latency", 32'(t_out - t_in), 32'd1);
    chk32("t1_beats", 32'(obs_data.size()), 32'd3);
    if (obs_data.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk32("t1_data", 32'(obs_data[k]), 32'(k + 1));
        chk32("t1_last", 32'(obs_last[k]), 32'(k == 2));
      end
    chk32("t1_count", packet_count, 32'd1);

    // All ports continuously requesting 2-beat packets
    do_reset(); clear_obs(); set_len(2);
    for (int i = 0; i < N; i++) begin pk_left[i] = 2; cnt[i] = 0; end
    run_pkts(8, 100, "t2_timeout");
    pk = 0;
    for (int k = 0; k < obs_port.size(); k++) begin
      if (k % 2 == 1) chk32("t2_no_interleave", 32'(obs_port[k]), 32'(obs_port[k-1]));
      if (obs_last[k]) begin
        chk32("t2_order", 32'(obs_port[k]), 32'(pk % N));
        cnt[obs_port[k]]++;
        pk++;
      end
    end
    for (int i = 0; i < N; i++) chk32("t2_per_port", 32'(cnt[i]), 32'd2);

    // Enable of the granted port dropped mid-packet
    clear_obs(); set_len(4); pk_left[2] = 2;
    step();
    port_enable[2] = 1'b0; plen[1] = 2; pk_left[1] = 1;
    run_pkts(2, 60, "t3_timeout");
    repeat (20) step();
    chk32("t3_disabled_idle", 32'(n_pkts), 32'd2);
    chk32("t3_beats", 32'(obs_port.size()), 32'd6);
    if (obs_port.size() == 6) begin
      for (int k = 0; k < 4; k++) begin
        chk32("t3_port2_beat", 32'(obs_port[k]), 32'd2);
        chk32("t3_port2_data", 32'(obs_data[k]), 32'(k + 1));
      end
      chk32("t3_next_grant", 32'(obs_port[4]), 32'd1);
    end
    port_enable[2] = 1'b1;
    run_pkts(3, 30, "t3_reenable_timeout");
    if (obs_port.size() > 0) chk32("t3_reenabled", 32'(obs_port[obs_port.size()-1]), 32'd2);

    // Downstream ready toggling during a 4-beat packet
    clear_obs(); set_len(4); pk_left[0] = 1;
    rdy_q.push_back(1'b1);
    for (int k = 0; k < 4; k++) begin rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); end
    run_pkts(1, 30, "t4_timeout");
    step();
    chk32("t4_cycles", 32'(t_last - t_in + 1), 32'd8);
    chk32("t4_beats", 32'(obs_data.size()), 32'd4);
    if (obs_data.size() == 4)
      for (int k = 0; k < 4; k++) chk32("t4_data", 32'(obs_data[k]), 32'(k + 1));

    // Packet counter wrap
    clear_obs();
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_cnt_q;
    m_count = 32'hFFFF_FFFE;
    set_len(1); pk_left[1] = 2;
    run_pkts(2, 30, "t5_timeout");
    step();
    chk32("t5_wrap", packet_count, 32'd0);

    // Reset in the middle of a 5-beat packet
    clear_obs(); set_len(5); pk_left[2] = 1;
    step(); step();
    drive();
    resetn = 1'b0;
    #1;
    chk32("t6_out_tvalid", 32'(out_tvalid), 32'd0);
    chk32("t6_grant_valid", 32'(grant_valid), 32'd0);
    chk32("t6_in_tready", 32'(in_tready), 32'd0);
    chk32("t6_packet_count", packet_count, 32'd0);
    reset_model();
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_obs(); set_len(1);
    for (int i = 0; i < N; i++) pk_left[i] = 1;
    run_pkts(1, 20, "t6_timeout");
    if (obs_port.size() > 0) chk32("t6_first_port", 32'(obs_port[0]), 32'd0);
    run_pkts(4, 40, "t6_drain_timeout");

    // Random traffic, enables and backpressure
    do_reset(); clear_obs();
    len_min = 1; len_max = 6;
    for (int i = 0; i < N; i++) begin plen[i] = int'($urandom_range(6, 1)); pk_left[i] = -1; end
    valid_pct = 70; rdy_pct = 60;
    for (int c = 0; c < 2500; c++) begin
      if (c % 100 == 0) port_enable = N'($urandom_range(15, 1));
      step();
    end
    chk32("t7_progress", 32'(n_pkts > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pktgen_arbiter.md
# pktgen_arbiter

Packet-atomic round-robin arbiter that shares one 512-bit AXI-Stream output between NUM_PORTS packet_gen-style source streams. It sits between several traffic sources and the single downstream UDP/Ethernet TX stream. Grant is held from the first beat of a packet through its TLAST beat, so packets are never interleaved. A per-port enable mask and a forwarded-packet counter give software control and visibility.

## Interface
- NUM_PORTS, 4, number of input streams (2..8)
- DATA_W, 512, stream data width in bits; TKEEP width is DATA_W/8
- clk  in  1  rising-edge clock; the single clock for the block
- resetn  in  1  asynchronous, active-low reset
- AXIS_IN_TDATA  in  NUM_PORTS*DATA_W  input data; port i occupies bits [i*DATA_W +: DATA_W]
- AXIS_IN_TKEEP  in  NUM_PORTS*DATA_W/8  input byte enables, packed the same way
- AXIS_IN_TLAST  in  NUM_PORTS  per-port end-of-packet
- AXIS_IN_TVALID  in  NUM_PORTS  per-port valid
- AXIS_IN_TREADY  out  NUM_PORTS  per-port ready
- AXIS_OUT_TDATA  out  DATA_W  output data
- AXIS_OUT_TKEEP  out  DATA_W/8  output byte enables
- AXIS_OUT_TLAST  out  1  output end-of-packet
- AXIS_OUT_TVALID  out  1  output valid
- AXIS_OUT_TREADY  in  1  downstream ready
- PORT_ENABLE  in  NUM_PORTS  1 = port may win arbitration
- GRANT_VALID  out  1  1 = a port currently holds the grant
- GRANT_IDX  out  3  index of the granted port (valid when GRANT_VALID)
- PACKET_COUNT  out  32  total packets forwarded since reset

## Operation
- States: IDLE and XFER.
- IDLE:
  - Candidates are the ports with AXIS_IN_TVALID[i] & PORT_ENABLE[i].
  - If any candidate exists, select the first one in the order last_grant+1, last_grant+2, … (mod NUM_PORTS).
  - Register the selection into GRANT_IDX and last_grant, set GRANT_VALID=1, go to XFER.
  - No candidate: stay in IDLE.
- XFER:
  - AXIS_OUT_* carry the granted port's TDATA/TKEEP/TLAST/TVALID (combinational mux).
  - AXIS_IN_TREADY[GRANT_IDX] = AXIS_OUT_TREADY; every other port's TREADY = 0.
  - Handshake (TVALID & TREADY) with TLAST=1: PACKET_COUNT += 1, GRANT_VALID=0, return to IDLE.
  - Handshake with TLAST=0: stay in XFER.
- Outside XFER: AXIS_OUT_TVALID=0, all AXIS_IN_TREADY=0, AXIS_OUT_TDATA/TKEEP/TLAST = 0.
- Grant is packet-atomic:
  - Deasserting PORT_ENABLE[GRANT_IDX] mid-packet does not end the grant; the packet completes.
  - The enable mask is sampled only in IDLE.
- A granted port deasserting TVALID mid-packet stalls the output (TVALID=0); the grant is held indefinitely.
- PACKET_COUNT is 32-bit unsigned and wraps 0xFFFFFFFF -> 0.
- GRANT_IDX is 3 bits regardless of NUM_PORTS; unused upper bits are 0.

## Timing
- Reset (asynchronous assert, released synchronously to clk):
  - state=IDLE, last_grant=NUM_PORTS-1 (so port 0 has first priority).
  - GRANT_VALID=0, GRANT_IDX=0, PACKET_COUNT=0.
  - AXIS_OUT_TVALID=0, AXIS_IN_TREADY=0.
- Reset mid-packet: outputs drop immediately; the partial packet is abandoned. Upstream and downstream are reset alongside.
- Arbitration latency: candidate TVALID sampled high in cycle N gives AXIS_OUT_TVALID=1 in cycle N+1.
- Inter-packet gap: exactly one idle cycle after each TLAST handshake. Back-to-back packets from one port therefore reach 1 packet per (beats+1) cycles.
- Combinational paths:
  - AXIS_OUT_TREADY -> AXIS_IN_TREADY.
  - AXIS_IN_* -> AXIS_OUT_*.
  - No other combinational paths.
- PACKET_COUNT updates on the clock edge after the TLAST handshake.
- Fairness: with all ports continuously requesting, each port gets exactly one packet per NUM_PORTS packets.

## Test plan
- Reset, then port 0 sends a 3-beat packet with TDATA=1,2,3 -> out TVALID high 1 cycle after port 0 TVALID; beats 1,2,3 with TLAST on beat 3; PACKET_COUNT=1; then IDLE for 1 cycle.
- Ports 0–3 all hold continuous 2-beat packets -> grant order 0,1,2,3,0,1…; after 8 packets each port's count is 2; no beats interleaved.
- Port 2 granted; PORT_ENABLE[2] cleared on beat 1 of 4; port 1 also requesting -> port 2's 4 beats complete; next grant is port 3 if requesting, else port 1; port 2 is not granted again while disabled.
- Downstream TREADY toggles 1,0,1,0 during a 4-beat packet -> only the granted port sees TREADY; data order preserved; completes in 8 cycles.
- Preload via 0xFFFFFFFF single-beat packets (or force) then send one more -> PACKET_COUNT wraps to 0.
- resetn asserted on beat 2 of a 5-beat packet -> same cycle: TVALID=0, GRANT_VALID=0, all TREADY=0; after release, port 0 has first priority.
